acc_write_sched: RTL and testbench
==================================

// Module: acc_write_sched
//
// PURPOSE
// - Sequences accumulator writes for one matrix-multiply instruction: accepts
//   (base addr, row count, accumulate flag) and issues one accumulator row
//   address per unstalled cycle.
// - Delays each issued row by the systolic-array latency so writes line up
//   with result rows.
// - Sits between the instruction dispatcher and the accumulator bank.
// - Replaces ad-hoc loading of acc_load_ctr.
//
// PARAMETERS
// - COUNTER_WIDTH  8   accumulator address width
// - LENGTH_WIDTH  16   row-count width of an instruction
// - MATRIX_WIDTH   4   systolic array dimension
// - PIPE_DELAY     7   cycles from row issue to result row (2*MATRIX_WIDTH-1); must be >= 1
//
// PORTS
// - clk              in   1              clock, rising edge
// - rst              in   1              asynchronous reset, active-low
// - instr_valid      in   1              instruction offered
// - instr_ready      out  1              block can accept an instruction
// - instr_acc_addr   in   COUNTER_WIDTH  first accumulator row address
// - instr_length     in   LENGTH_WIDTH   number of rows L (0 allowed)
// - instr_accumulate in   1              1 = add to row contents, 0 = overwrite
// - stall            in   1              freeze: no issue, no write, no state change
// - acc_wr_en        out  1              accumulator row write strobe
// - acc_wr_addr      out  COUNTER_WIDTH  accumulator row address
// - acc_accumulate   out  1              accumulate flag for this write
// - busy             out  1              instruction in flight (not IDLE)
// - done             out  1              one-cycle pulse: instruction finished
//
// BEHAVIOUR
// - Reset (rst=0, async):
//   - State goes to IDLE and the delay line clears.
//   - All outputs are 0, except instr_ready = 1 once rst deasserts.
// - FSM states:
//   - IDLE: instr_ready = !stall. On valid && ready, latch the fields and go to RUN.
//     If L = 0, stay in IDLE and pulse done in the next cycle; no writes.
//   - RUN: in each !stall cycle, push row k (k = 0..L-1) into the delay line:
//     addr = base + k mod 2^COUNTER_WIDTH (wraps silently), flag = latched accumulate.
//     After row L-1, go to DRAIN.
//   - DRAIN: in each !stall cycle, push bubbles until row L-1 exits the delay line.
//     Then go to IDLE.
// - Timing:
//   - Row k exits PIPE_DELAY unstalled edges after its issue edge.
//   - With no stall: handshake at edge 0, then row k write visible after edge
//     k+1+PIPE_DELAY. First write is PIPE_DELAY+1 cycles after accept.
// - done and IDLE:
//   - done is high in the same cycle as the last write.
//   - The FSM is already IDLE in that cycle, so instr_ready = 1 then (back-to-back
//     allowed). A new row cannot reach the output before the old one has drained.
// - Stall:
//   - While stall = 1: acc_wr_en = 0, and the FSM, row index and delay line hold.
//   - done is suppressed while stalled; it fires in the first cycle after stall
//     drops in which the last write is visible.
// - Outputs:
//   - busy = (state != IDLE).
//   - acc_wr_addr and acc_accumulate are don't-care when acc_wr_en = 0; drive them to 0.
//   - Row counter is LENGTH_WIDTH bits, so L = 2^LENGTH_WIDTH-1 must work.
// - Reset mid-operation: in-flight rows are discarded, no write or done is emitted,
//   and the block is IDLE after reset.
//
// STRUCTURE
// - tpu_pkg:
//   - typedef acc_instr_t struct {addr, length, accumulate}.
//   - typedef acc_sched_state_e enum {IDLE, RUN, DRAIN}.
//   - typedef acc_wr_t struct {en, addr, accumulate}.
// - Sub-module acc_delay_line:
//   - PIPE_DELAY-stage shift register of acc_wr_t with hold (stall) input.
//   - Async active-low clear.
// - The top level holds the FSM, row counter and drain counter.
//
// TESTING
// 1. Reset: rst=0 mid-RUN (base 3, L 6, after 2 issues)
//    -> outputs 0 immediately; after release instr_ready=1, no writes ever appear.
// 2. Basic: base 5, L 4, acc 0, no stall
//    -> acc_wr_en high 4 consecutive cycles starting 8 cycles after accept,
//       addr 5,6,7,8, acc_accumulate 0; done with addr 8.
// 3. Wrap: base 254, L 4, acc 1
//    -> addr 254,255,0,1 with acc_accumulate 1; busy drops with done.
// 4. Stall: base 0, L 4, stall high 3 cycles after 2nd issue
//    -> addr 0,1,2,3 still in order and contiguous per unstalled cycle;
//       no acc_wr_en while stalled; done delayed by exactly 3 cycles.
// 5. L = 0
//    -> accepted, done pulses next cycle, no acc_wr_en, busy stays 0.
// 6. Back-to-back: (10,L2) then (20,L3) with valid held
//    -> second accepted on the first's done cycle; writes 10,11 then 20,21,22,
//       two done pulses.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types for the accumulator write scheduler: instruction fields,
// scheduler FSM states and the per-row write descriptor.
package tpu_pkg;

   localparam int TPU_COUNTER_WIDTH = 8;
   localparam int TPU_LENGTH_WIDTH  = 16;
   localparam int TPU_MATRIX_WIDTH  = 4;

   typedef struct packed {
      logic [TPU_COUNTER_WIDTH-1:0] addr;
      logic [TPU_LENGTH_WIDTH-1:0]  length;
      logic                         accumulate;
   } acc_instr_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } acc_sched_state_e;

   typedef struct packed {
      logic                         en;
      logic [TPU_COUNTER_WIDTH-1:0] addr;
      logic                         accumulate;
   } acc_wr_t;

endpackage

// File: rtl/acc_delay_line.sv
// Fixed-depth shift register of write descriptors; the whole line freezes
// while hold is high so rows keep their spacing across stalls.
module acc_delay_line
   import tpu_pkg::*;
#(
   parameter int DEPTH = 7
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    hold,
   input  acc_wr_t din,
   output acc_wr_t dout
);

   acc_wr_t [DEPTH-1:0] stage_q;
   acc_wr_t [DEPTH-1:0] stage_d;

   always_comb begin
      stage_d = stage_q;
      if (!hold) begin
         stage_d[0] = din;
         for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/acc_write_sched.sv
// Accumulator write scheduler: turns one (base, length, accumulate) instruction
// into a row-address stream delayed to line up with systolic-array results.
module acc_write_sched
   import tpu_pkg::*;
#(
   parameter int COUNTER_WIDTH = TPU_COUNTER_WIDTH,
   parameter int LENGTH_WIDTH  = TPU_LENGTH_WIDTH,
   parameter int MATRIX_WIDTH  = TPU_MATRIX_WIDTH,
   parameter int PIPE_DELAY    = 2 * MATRIX_WIDTH - 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     instr_valid,
   output logic                     instr_ready,
   input  logic [COUNTER_WIDTH-1:0] instr_acc_addr,
   input  logic [LENGTH_WIDTH-1:0]  instr_length,
   input  logic                     instr_accumulate,
   input  logic                     stall,
   output logic                     acc_wr_en,
   output logic [COUNTER_WIDTH-1:0] acc_wr_addr,
   output logic                     acc_accumulate,
   output logic                     busy,
   output logic                     done
);

   localparam int DRAIN_W = (PIPE_DELAY > 1) ? $clog2(PIPE_DELAY) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_DELAY - 1);

   acc_sched_state_e         state_q, state_d;
   acc_instr_t               instr_q, instr_d;
   logic [LENGTH_WIDTH-1:0]  row_q, row_d;
   logic [DRAIN_W-1:0]       drain_q, drain_d;
   acc_wr_t                  issue_q, issue_d;
   logic                     done_q, done_d;
   acc_wr_t                  wr_out;
   logic                     accept;

   // instr_ready is held low while reset is asserted, not just after it.
   assign instr_ready = rst & (state_q == IDLE) & ~stall;
   assign accept      = instr_valid & instr_ready;

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      row_d   = row_q;
      drain_d = drain_q;
      issue_d = issue_q;
      done_d  = done_q;
      if (!stall) begin
         issue_d = '0;
         done_d  = 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  instr_d.addr       = instr_acc_addr;
                  instr_d.length     = instr_length;
                  instr_d.accumulate = instr_accumulate;
                  row_d              = '0;
                  if (instr_length == '0) begin
                     done_d = 1'b1;
                  end else begin
                     state_d = RUN;
                  end
               end
            end
            RUN: begin
               issue_d.en         = 1'b1;
               issue_d.addr       = instr_q.addr;
               issue_d.accumulate = instr_q.accumulate;
               instr_d.addr       = instr_q.addr + 1'b1;
               row_d              = row_q + 1'b1;
               if (row_q == instr_q.length - 1'b1) begin
                  state_d = DRAIN;
                  drain_d = '0;
               end
            end
            DRAIN: begin
               // Last row leaves the delay line on this edge, so we are IDLE
               // in the same cycle its write is visible.
               if (drain_q == DRAIN_LAST) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  drain_d = drain_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         instr_q <= '0;
         row_q   <= '0;
         drain_q <= '0;
         issue_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         row_q   <= row_d;
         drain_q <= drain_d;
         issue_q <= issue_d;
         done_q  <= done_d;
      end
   end

   acc_delay_line #(
      .DEPTH (PIPE_DELAY)
   ) u_delay (
      .clk   (clk),
      .rst_n (rst),
      .hold  (stall),
      .din   (issue_q),
      .dout  (wr_out)
   );

   assign acc_wr_en      = wr_out.en & ~stall;
   assign acc_wr_addr    = acc_wr_en ? wr_out.addr : '0;
   assign acc_accumulate = acc_wr_en & wr_out.accumulate;
   assign busy           = (state_q != IDLE);
   assign done           = done_q & ~stall;

endmodule

// File: tb/tb_acc_write_sched.sv
// Randomized bench for acc_write_sched with a queue-based reference model
// timed in unstalled clock edges.
module tb_acc_write_sched;

   localparam int PD = 7;

   logic        clk;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [7:0]  instr_acc_addr;
   logic [15:0] instr_length;
   logic        instr_accumulate;
   logic        stall;
   logic        acc_wr_en;
   logic [7:0]  acc_wr_addr;
   logic        acc_accumulate;
   logic        busy;
   logic        done;

   acc_write_sched dut (
      .clk              (clk),
      .rst              (rst),
      .instr_valid      (instr_valid),
      .instr_ready      (instr_ready),
      .instr_acc_addr   (instr_acc_addr),
      .instr_length     (instr_length),
      .instr_accumulate (instr_accumulate),
      .stall            (stall),
      .acc_wr_en        (acc_wr_en),
      .acc_wr_addr      (acc_wr_addr),
      .acc_accumulate   (acc_accumulate),
      .busy             (busy),
      .done             (done)
   );

   typedef struct {
      longint     t;
      logic [7:0] addr;
      logic       acc;
   } wexp_t;

   wexp_t  wq[$];
   longint dq[$];
   longint ucnt      = 0;
   longint busy_from = 0;
   longint busy_to   = 0;
   int     checks    = 0;
   int     errors    = 0;
   bit     force_stall = 0;
   bit     rnd_stall   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at u=%0d: got %0d expected %0d", name, ucnt, act, exp);
      end
   endtask

   // Sole driver of stall; runs later in the cycle than the main stimulus.
   initial begin
      stall = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         stall = force_stall | (rnd_stall & ($urandom_range(0, 3) == 0));
      end
   end

   // Monitor / reference model: every time is counted in unstalled edges.
   always @(negedge clk) begin
      logic  exp_busy, exp_wr, exp_done;
      wexp_t w;
      if (!rst) begin
         wq.delete();
         dq.delete();
         busy_from = 0;
         busy_to   = 0;
         chk("rst_wr_en", acc_wr_en, 0);
         chk("rst_addr", acc_wr_addr, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_ready", instr_ready, 0);
      end else begin
         exp_busy = (ucnt >= busy_from) && (ucnt < busy_to);
         chk("busy", busy, exp_busy);
         chk("ready", instr_ready, !stall && !exp_busy);
         if (stall) begin
            chk("stall_wr_en", acc_wr_en, 0);
            chk("stall_done", done, 0);
         end else begin
            exp_wr = (wq.size() > 0) && (wq[0].t == ucnt);
            chk("wr_en", acc_wr_en, exp_wr);
            if (exp_wr) begin
               w = wq.pop_front();
               if (acc_wr_en) begin
                  chk("wr_addr", acc_wr_addr, w.addr);
                  chk("wr_acc", acc_accumulate, w.acc);
               end
            end
            exp_done = (dq.size() > 0) && (dq[0] == ucnt);
            chk("done", done, exp_done);
            if (exp_done) void'(dq.pop_front());
         end
         if (!acc_wr_en) begin
            chk("idle_addr", acc_wr_addr, 0);
            chk("idle_acc", acc_accumulate, 0);
         end
         if (instr_valid && instr_ready) begin
            longint a;
            a = ucnt + 1;
            if (instr_length == 0) begin
               dq.push_back(a);
            end else begin
               for (int k = 0; k < int'(instr_length); k++) begin
                  w.t    = a + k + 1 + PD;
                  w.addr = instr_acc_addr + 8'(k);
                  w.acc  = instr_accumulate;
                  wq.push_back(w);
               end
               dq.push_back(a + instr_length + PD);
               busy_from = a;
               busy_to   = a + instr_length + PD;
            end
         end
         if (!stall) ucnt++;
      end
   end

   task automatic issue(input logic [7:0] b, input logic [15:0] l, input logic ac);
      int n;
      bit got;
      n   = 0;
      got = 0;
      instr_valid      = 1'b1;
      instr_acc_addr   = b;
      instr_length     = l;
      instr_accumulate = ac;
      while (!got && n < 4000) begin
         @(negedge clk);
         if (instr_ready && rst) got = 1;
         n++;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout base=%0d len=%0d waited %0d cycles", b, l, n);
      end
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((wq.size() != 0 || dq.size() != 0 || busy) && n < 5000) begin
         @(posedge clk);
         n++;
      end
      #1;
      checks++;
      if (n >= 5000) begin
         errors++;
         $display("FAIL drain_timeout pending writes %0d pending done %0d", wq.size(), dq.size());
      end
   endtask

   initial begin
      rst              = 1'b0;
      instr_valid      = 1'b0;
      instr_acc_addr   = '0;
      instr_length     = '0;
      instr_accumulate = 1'b0;
      idle_cycles(3);
      rst = 1'b1;
      idle_cycles(2);

      // Reset in the middle of a RUN phase
      issue(8'd3, 16'd6, 1'b0);
      idle_cycles(2);
      rst = 1'b0;
      #1;
      chk("async_rst_busy", busy, 0);
      chk("async_rst_ready", instr_ready, 0);
      idle_cycles(2);
      rst = 1'b1;
      idle_cycles(PD + 12);

      // Basic, wrap, stall, zero length
      issue(8'd5, 16'd4, 1'b0);
      wait_drain();
      issue(8'd254, 16'd4, 1'b1);
      wait_drain();
      issue(8'd0, 16'd4, 1'b0);
      idle_cycles(2);
      force_stall = 1'b1;
      idle_cycles(3);
      force_stall = 1'b0;
      wait_drain();
      issue(8'd77, 16'd0, 1'b1);
      idle_cycles(4);

      // Back-to-back with valid held high between instructions
      issue(8'd10, 16'd2, 1'b0);
      issue(8'd20, 16'd3, 1'b1);
      wait_drain();
      issue(8'd30, 16'd0, 1'b0);
      issue(8'd40, 16'd1, 1'b1);
      wait_drain();

      // Randomized traffic with random stalls, plus one long wrapping run
      rnd_stall = 1'b1;
      for (int i = 0; i < 40; i++) begin
         logic [15:0] l;
         l = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
         issue(8'($urandom_range(0, 255)), l, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(0, 3));
      end
      issue(8'($urandom_range(0, 255)), 16'd300, 1'b1);
      wait_drain();
      rnd_stall = 1'b0;
      idle_cycles(PD + 4);

      chk("writes_left", wq.size(), 0);
      chk("dones_left", dq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
